// File: rtl/i2c_slave_regs.sv
// I2C target with register pointer, auto-increment and external register-bus strobes.
// Optional `I2C_SLV_GLITCH_FILTER_EN adds a 3-sample majority filter on SCL/SDA.
module i2c_slave_regs #(
  parameter logic [6:0] I2C_ADR    = 7'h10,
  parameter int         ADDR_BYTES = 1,
  parameter int         DEPTH      = 16,
  parameter bit         WRAP       = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    scl_i,
  input  logic                    sda_i,
  output logic                    sda_oe,
  output logic                    reg_we,
  output logic [8*ADDR_BYTES-1:0] reg_waddr,
  output logic [7:0]              reg_wdata,
  output logic                    reg_re,
  output logic [8*ADDR_BYTES-1:0] reg_raddr,
  input  logic [7:0]              reg_rdata,
  output logic                    busy,
  output logic                    start_det,
  output logic                    stop_det
);
  localparam int AW = 8*ADDR_BYTES;
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEP    = PW'(DEPTH);
  localparam logic [PW-1:0] DEP_M1 = PW'(DEPTH - 1);
  localparam logic          AB_LAST = (ADDR_BYTES == 2);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV, S_DEV_ACK, S_REG, S_REG_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK
  } state_t;

  state_t          state_q;
  logic [1:0]      scl_sync_q, sda_sync_q;
  logic            scl_p_q, sda_p_q, scl, sda;
  logic [7:0]      sr_q, addr_sh_q;
  logic [2:0]      cnt_q;
  logic            ph_q, ack_q, rw_q, ab_q, re_d1_q;
  logic [PW-1:0]   ptr_q, ptr_nx, ld_ptr;
  logic [AW-1:0]   ld_addr;
  logic [7:0]      byte_in;
  logic            sda_oe_q, reg_we_q, reg_re_q, busy_q;
  logic [AW-1:0]   reg_waddr_q, reg_raddr_q;
  logic [7:0]      reg_wdata_q;
  logic            scl_rise, scl_fall, start_ev, stop_ev;

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] scl_h_q, sda_h_q;
  logic       scl_f_q, sda_f_q;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_h_q <= 2'b11; sda_h_q <= 2'b11; scl_f_q <= 1'b1; sda_f_q <= 1'b1;
    end else begin
      scl_h_q <= {scl_h_q[0], scl_sync_q[1]};
      sda_h_q <= {sda_h_q[0], sda_sync_q[1]};
      scl_f_q <= maj3(scl_sync_q[1], scl_h_q[0], scl_h_q[1]);
      sda_f_q <= maj3(sda_sync_q[1], sda_h_q[0], sda_h_q[1]);
    end
  end
  assign scl = scl_f_q;
  assign sda = sda_f_q;
`else
  assign scl = scl_sync_q[1];
  assign sda = sda_sync_q[1];
`endif

  assign scl_rise = scl & ~scl_p_q;
  assign scl_fall = ~scl & scl_p_q;
  assign start_ev = scl_p_q & sda_p_q & ~sda;
  assign stop_ev  = scl_p_q & ~sda_p_q & sda;
  assign byte_in  = {sr_q[6:0], sda};
  // Upper address byte (2-byte mode) is prepended; in 1-byte mode it shifts out of range.
  assign ld_addr  = (AW'(addr_sh_q) << 8) | AW'(byte_in);
  assign ld_ptr   = {1'b0, ld_addr};

  always_comb begin
    ptr_nx = ptr_q + 1'b1;
    if (WRAP) begin
      if (ptr_q >= DEP_M1) ptr_nx = '0;
    end else begin
      if (ptr_q >= DEP) ptr_nx = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      scl_sync_q <= 2'b11; sda_sync_q <= 2'b11; scl_p_q <= 1'b1; sda_p_q <= 1'b1;
      sr_q <= '0; addr_sh_q <= '0; cnt_q <= '0; ph_q <= 1'b0; ack_q <= 1'b0;
      rw_q <= 1'b0; ab_q <= 1'b0; re_d1_q <= 1'b0; ptr_q <= '0;
      sda_oe_q <= 1'b0; reg_we_q <= 1'b0; reg_re_q <= 1'b0; busy_q <= 1'b0;
      reg_waddr_q <= '0; reg_raddr_q <= '0; reg_wdata_q <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_p_q    <= scl;
      sda_p_q    <= sda;
      reg_we_q   <= 1'b0;
      reg_re_q   <= 1'b0;
      re_d1_q    <= reg_re_q;
      if (re_d1_q) sr_q <= reg_rdata;
      if (start_ev) begin
        state_q <= S_DEV; cnt_q <= '0; sda_oe_q <= 1'b0;
      end else if (stop_ev) begin
        state_q <= S_IDLE; busy_q <= 1'b0; sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_DEV: if (scl_rise) begin
            sr_q <= byte_in; cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              if (byte_in[7:1] == I2C_ADR) begin
                rw_q <= byte_in[0]; busy_q <= 1'b1; ph_q <= 1'b0; state_q <= S_DEV_ACK;
              end else begin
                state_q <= S_IDLE; busy_q <= 1'b0;
              end
            end
          end
          S_DEV_ACK: begin
            if (scl_fall && !ph_q) begin
              sda_oe_q <= 1'b1; ph_q <= 1'b1;
            end else if (scl_rise && ph_q && rw_q) begin
              if (ptr_q < DEP) begin reg_re_q <= 1'b1; reg_raddr_q <= ptr_q[AW-1:0]; end
              else sr_q <= 8'hFF;
            end else if (scl_fall && ph_q) begin
              cnt_q <= '0; ab_q <= 1'b0;
              if (rw_q) begin
                state_q <= S_RD; sda_oe_q <= ~sr_q[7]; sr_q <= {sr_q[6:0], 1'b1};
              end else begin
                state_q <= S_REG; sda_oe_q <= 1'b0;
              end
            end
          end
          S_REG: if (scl_rise) begin
            sr_q <= byte_in; cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ph_q <= 1'b0; state_q <= S_REG_ACK;
              if (ab_q == AB_LAST) begin ptr_q <= ld_ptr; ack_q <= (ld_ptr < DEP); end
              else begin addr_sh_q <= byte_in; ack_q <= 1'b1; end
            end
          end
          S_REG_ACK: begin
            if (scl_fall && !ph_q) begin
              sda_oe_q <= ack_q; ph_q <= 1'b1;
            end else if (scl_fall && ph_q) begin
              sda_oe_q <= 1'b0; cnt_q <= '0;
              if (ab_q == AB_LAST) state_q <= S_WR;
              else begin ab_q <= 1'b1; state_q <= S_REG; end
            end
          end
          S_WR: if (scl_rise) begin
            sr_q <= byte_in; cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
              ph_q <= 1'b0; state_q <= S_WR_ACK; ack_q <= (ptr_q < DEP);
              if (ptr_q < DEP) begin
                reg_we_q <= 1'b1; reg_waddr_q <= ptr_q[AW-1:0]; reg_wdata_q <= byte_in;
                ptr_q <= ptr_nx;
              end
            end
          end
          S_WR_ACK: begin
            if (scl_fall && !ph_q) begin
              sda_oe_q <= ack_q; ph_q <= 1'b1;
            end else if (scl_fall && ph_q) begin
              sda_oe_q <= 1'b0; cnt_q <= '0; state_q <= S_WR;
            end
          end
          S_RD: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin ph_q <= 1'b0; state_q <= S_RD_ACK; end
            end else if (scl_fall) begin
              sda_oe_q <= ~sr_q[7]; sr_q <= {sr_q[6:0], 1'b1};
            end
          end
          S_RD_ACK: begin
            if (scl_fall && !ph_q) begin
              sda_oe_q <= 1'b0; ph_q <= 1'b1;
            end else if (scl_rise && ph_q) begin
              ack_q <= ~sda;
              if (!sda) begin
                ptr_q <= ptr_nx;
                if (ptr_nx < DEP) begin reg_re_q <= 1'b1; reg_raddr_q <= ptr_nx[AW-1:0]; end
                else sr_q <= 8'hFF;
              end
            end else if (scl_fall && ph_q) begin
              cnt_q <= '0;
              if (ack_q) begin
                state_q <= S_RD; sda_oe_q <= ~sr_q[7]; sr_q <= {sr_q[6:0], 1'b1};
              end else begin
                state_q <= S_IDLE; busy_q <= 1'b0; sda_oe_q <= 1'b0;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sda_oe    = sda_oe_q;
  assign reg_we    = reg_we_q;
  assign reg_waddr = reg_waddr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_re    = reg_re_q;
  assign reg_raddr = reg_raddr_q;
  assign busy      = busy_q;
  assign start_det = start_ev & ~rst;
  assign stop_det  = stop_ev & ~rst;
endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench: bit-banged I2C master against a WRAP=1 and a WRAP=0 target on separate SDA lines.
module tb_i2c_slave_regs;
  localparam int Q = 8;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, sda_m = 1'b1;
  logic oe_a, we_a, re_a, busy_a, st_a, sp_a;
  logic oe_b, we_b, re_b, busy_b, st_b, sp_b;
  logic [7:0] wa_a, wd_a, ra_a, rd_a, wa_b, wd_b, ra_b, rd_b;
  wire sda_a = sda_m & ~oe_a;
  wire sda_b = sda_m & ~oe_b;
  assign rd_a = ra_a ^ 8'hF0;
  assign rd_b = ra_b ^ 8'hF0;
  always #5 clk = ~clk;

  i2c_slave_regs #(.I2C_ADR(7'h10), .ADDR_BYTES(1), .DEPTH(16), .WRAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_a), .sda_oe(oe_a),
    .reg_we(we_a), .reg_waddr(wa_a), .reg_wdata(wd_a), .reg_re(re_a), .reg_raddr(ra_a),
    .reg_rdata(rd_a), .busy(busy_a), .start_det(st_a), .stop_det(sp_a));
  i2c_slave_regs #(.I2C_ADR(7'h10), .ADDR_BYTES(1), .DEPTH(16), .WRAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_b), .sda_oe(oe_b),
    .reg_we(we_b), .reg_waddr(wa_b), .reg_wdata(wd_b), .reg_re(re_b), .reg_raddr(ra_b),
    .reg_rdata(rd_b), .busy(busy_b), .start_det(st_b), .stop_det(sp_b));

  int n_chk = 0, n_pass = 0;
  int n_start = 0, n_stop = 0;
  bit busy_seen = 1'b0;
  logic [15:0] q_we_a[$], q_we_b[$];
  logic [7:0]  q_re_a[$], q_re_b[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
  endtask

  // Scoreboard monitors: pop expected strobes as the DUTs issue them.
  always @(negedge clk) begin
    if (!rst) begin
      if (we_a) begin
        if (q_we_a.size() == 0) check("we_a_unexpected", {wa_a, wd_a}, 32'hDEAD);
        else check("we_a", {wa_a, wd_a}, q_we_a.pop_front());
      end
      if (we_b) begin
        if (q_we_b.size() == 0) check("we_b_unexpected", {wa_b, wd_b}, 32'hDEAD);
        else check("we_b", {wa_b, wd_b}, q_we_b.pop_front());
      end
      if (re_a) begin
        if (q_re_a.size() == 0) check("re_a_unexpected", ra_a, 32'hDEAD);
        else check("re_a", ra_a, q_re_a.pop_front());
      end
      if (re_b) begin
        if (q_re_b.size() == 0) check("re_b_unexpected", ra_b, 32'hDEAD);
        else check("re_b", ra_b, q_re_b.pop_front());
      end
      if (st_a) n_start++;
      if (sp_a) n_stop++;
      if (busy_a || busy_b) busy_seen = 1'b1;
    end
  end

  task automatic wt(input int n); repeat (n) @(negedge clk); endtask
  task automatic i2c_start; sda_m = 1; wt(Q); scl = 1; wt(Q); sda_m = 0; wt(Q); scl = 0; wt(Q); endtask
  task automatic i2c_stop;  sda_m = 0; wt(Q); scl = 1; wt(Q); sda_m = 1; wt(Q); endtask
  task automatic wr_bit(input logic b); sda_m = b; wt(Q); scl = 1; wt(2*Q); scl = 0; wt(Q); endtask
  task automatic rd_bit(output logic ba, output logic bb);
    sda_m = 1; wt(Q); scl = 1; wt(Q); ba = sda_a; bb = sda_b; wt(Q); scl = 0; wt(Q);
  endtask
  task automatic wr_byte(input logic [7:0] d, input logic ea, input logic eb, input string nm);
    logic ba, bb;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(ba, bb);
    check({nm, "_ackA"}, !ba, ea);
    check({nm, "_ackB"}, !bb, eb);
  endtask
  task automatic rd_byte(input logic [7:0] ea, input logic [7:0] eb, input logic mack, input string nm);
    logic ba, bb;
    logic [7:0] ga, gb;
    for (int i = 7; i >= 0; i--) begin rd_bit(ba, bb); ga[i] = ba; gb[i] = bb; end
    check({nm, "_dataA"}, ga, ea);
    check({nm, "_dataB"}, gb, eb);
    wr_bit(!mack);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    wt(5);
    check("rst_sda_oe", {oe_a, oe_b}, 0);
    check("rst_strobes", {we_a, re_a, we_b, re_b}, 0);
    check("rst_addr_data", {wa_a, ra_a, wd_a}, 0);
    check("rst_flags", {busy_a, st_a, sp_a, busy_b}, 0);
    rst = 0; wt(10);

    // Write 0xA5, 0x5A starting at reg 3
    n_stop = 0; n_start = 0;
    i2c_start; wr_byte(8'h20, 1, 1, "w1_dev"); wr_byte(8'h03, 1, 1, "w1_reg");
    q_we_a.push_back(16'h03A5); q_we_b.push_back(16'h03A5); wr_byte(8'hA5, 1, 1, "w1_d0");
    q_we_a.push_back(16'h045A); q_we_b.push_back(16'h045A); wr_byte(8'h5A, 1, 1, "w1_d1");
    i2c_stop; wt(10);
    check("w1_stop_cnt", n_stop, 1);
    check("w1_start_cnt", n_start, 1);
    check("w1_busy_after", busy_a, 0);

    // Set reg 2, repeated START, read 3 bytes, master NACK on the last
    i2c_start; wr_byte(8'h20, 1, 1, "r_dev"); wr_byte(8'h02, 1, 1, "r_reg");
    i2c_start;
    q_re_a.push_back(8'h02); q_re_b.push_back(8'h02); wr_byte(8'h21, 1, 1, "r_devr");
    q_re_a.push_back(8'h03); q_re_b.push_back(8'h03); rd_byte(8'hF2, 8'hF2, 1, "r_b0");
    q_re_a.push_back(8'h04); q_re_b.push_back(8'h04); rd_byte(8'hF3, 8'hF3, 1, "r_b1");
    rd_byte(8'hF4, 8'hF4, 0, "r_b2");
    wt(10);
    check("r_busy_after_nack", {busy_a, busy_b}, 0);
    i2c_stop; wt(10);

    // Wrong device address, then a valid write
    busy_seen = 0;
    i2c_start; wr_byte(8'h22, 0, 0, "bad_dev"); wr_byte(8'h05, 0, 0, "bad_reg"); i2c_stop; wt(10);
    check("bad_busy_seen", busy_seen, 0);
    i2c_start; wr_byte(8'h20, 1, 1, "ok_dev"); wr_byte(8'h07, 1, 1, "ok_reg");
    q_we_a.push_back(16'h0711); q_we_b.push_back(16'h0711); wr_byte(8'h11, 1, 1, "ok_d0");
    i2c_stop; wt(10);

    // Burst across reg 15: WRAP=1 wraps to 0, WRAP=0 saturates and refuses
    i2c_start; wr_byte(8'h20, 1, 1, "wr_dev"); wr_byte(8'h0F, 1, 1, "wr_reg");
    q_we_a.push_back(16'h0FC1); q_we_b.push_back(16'h0FC1); wr_byte(8'hC1, 1, 1, "wr_d0");
    q_we_a.push_back(16'h00C2); wr_byte(8'hC2, 1, 0, "wr_d1");
    q_we_a.push_back(16'h01C3); wr_byte(8'hC3, 1, 0, "wr_d2");
    i2c_stop; wt(10);

    // Read at current pointers: A at 2, B saturated at 16 -> 0xFF without strobe
    i2c_start; q_re_a.push_back(8'h02); wr_byte(8'h21, 1, 1, "oor_dev");
    rd_byte(8'hF2, 8'hFF, 0, "oor_b0");
    i2c_stop; wt(10);

    // Reset while ACK is being driven
    i2c_start;
    for (int i = 7; i >= 0; i--) wr_bit(logic'((8'h20 >> i) & 1));
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin if (oe_a && oe_b) seen = 1; else wt(1); end
    check("ack_driven_before_rst", seen, 1);
    rst = 1; @(posedge clk); #1;
    check("rst_mid_sda_oe", {oe_a, oe_b}, 0);
    check("rst_mid_busy", {busy_a, busy_b}, 0);
    @(negedge clk); rst = 0;
    i2c_stop; wt(10);
    i2c_start; q_re_a.push_back(8'h00); q_re_b.push_back(8'h00); wr_byte(8'h21, 1, 1, "p0_dev");
    rd_byte(8'hF0, 8'hF0, 0, "p0_b0");
    i2c_stop; wt(10);

    // 1-clk SDA low glitch with SCL high
    n_start = 0;
    sda_m = 0; wt(1); sda_m = 1; wt(20);
`ifdef I2C_SLV_GLITCH_FILTER_EN
    check("glitch_start", n_start, 0);
`else
    check("glitch_start", n_start, 1);
`endif

    check("q_we_a_empty", q_we_a.size(), 0);
    check("q_we_b_empty", q_we_b.size(), 0);
    check("q_re_a_empty", q_re_a.size(), 0);
    check("q_re_b_empty", q_re_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

Synthesizable, parametrised I2C target with an internal register pointer and an external register-bus port. It oversamples SCL/SDA on the system clock. It supports 1- or 2-byte register addressing, a configurable register depth with bounds-checked ACK/NACK, and auto-increment with optional wrap. It sits between the board-level open-drain pads (via pad cells driven by `sda_oe`) and the block's register file.

## Interface
- `I2C_ADR`, 7'h10, 7-bit device address matched on the first byte after START.
- `ADDR_BYTES`, 1, register-address bytes after the device byte (1 or 2; MSB byte first).
- `DEPTH`, 16, number of valid registers (1..2^(8*ADDR_BYTES)).
- `WRAP`, 1, 1 = pointer wraps DEPTH-1 -> 0; 0 = pointer saturates at DEPTH and out-of-range access is refused.
- `clk`  in  1  system clock; must be >= 20x SCL frequency.
- `rst`  in  1  synchronous, active-high reset.
- `scl_i`  in  1  SCL pad input (asynchronous).
- `sda_i`  in  1  SDA pad input (asynchronous).
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `reg_we`  out  1  one-clk write strobe.
- `reg_waddr`  out  8*ADDR_BYTES  write address.
- `reg_wdata`  out  8  write data.
- `reg_re`  out  1  one-clk read strobe; data is due on `reg_rdata` exactly 1 clk later.
- `reg_raddr`  out  8*ADDR_BYTES  read address.
- `reg_rdata`  in  8  read data, sampled 1 clk after `reg_re`.
- `busy`  out  1  high from an addressed START until STOP or release to IDLE.
- `start_det`  out  1  one-clk pulse per START or repeated START.
- `stop_det`  out  1  one-clk pulse per STOP.

## Operation
- SCL and SDA each pass through a 2-FF synchronizer. Rise/fall events come from the synced value against its previous sample.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are valid in every state and take priority over bit events in the same clk.
- Bits are sampled on SCL rise into an 8-bit shift register, MSB first. A 3-bit counter counts bits.
- `sda_oe` changes only on the clk after an SCL fall.
- States:
  - IDLE: wait for START.
  - DEV_ADDR: receive 8 bits. On match, go to DEV_ACK. On mismatch, return to IDLE with SDA released.
  - DEV_ACK: drive ACK.
    - R/W=0: go to REG_ADDR.
    - R/W=1: pulse `reg_re` at the pointer, then go to RD_DATA.
  - REG_ADDR: receive ADDR_BYTES bytes, each followed by REG_ACK. The final byte loads the pointer.
    - ACK if the loaded pointer < DEPTH; otherwise NACK.
    - Then go to WR_DATA.
  - WR_DATA: receive byte. If pointer < DEPTH: ACK (WR_ACK), pulse `reg_we` with `reg_waddr`=pointer and `reg_wdata`=byte on the 8th SCL rise + 1 clk, then increment the pointer. Otherwise NACK, no strobe.
  - RD_DATA: shift the loaded byte out MSB first, then release SDA for the master ACK (RD_ACK).
    - Master ACK: increment the pointer, pulse `reg_re`, return to RD_DATA.
    - Master NACK: go to IDLE.
- Out-of-range read (pointer >= DEPTH, WRAP=0): no `reg_re`; 8'hFF is shifted out.
- Repeated START in any state: go to DEV_ADDR, pointer kept (enables write-address-then-read).
- STOP: go to IDLE, `busy`=0, pointer kept.
- Pointer width is 8*ADDR_BYTES+1 bits. With WRAP=1, the increment from DEPTH-1 yields 0. With WRAP=0, the pointer saturates at DEPTH.

## Timing
- Reset values: `sda_oe`=0, `reg_we`=0, `reg_re`=0, `reg_waddr`=0, `reg_raddr`=0, `reg_wdata`=0, `busy`=0, `start_det`=0, `stop_det`=0, pointer=0, state IDLE. Reset mid-transfer releases SDA on the next clk.
- Input-to-event latency: 3 clk (2 sync + edge detect).
- ACK drive: `sda_oe` rises 1 clk after the synced 8th-bit SCL fall and falls 1 clk after the synced 9th SCL fall.
- Read data: `reg_re` is issued on the clk after the ACK-bit SCL rise. `reg_rdata` is captured 1 clk later, well before the next SCL fall that drives the MSB.
- `start_det`/`stop_det` assert on the clk the condition is detected.
- A single SDA edge qualifies as START or STOP only if SCL was high in the preceding synced sample.

## Configuration
- `I2C_SLV_GLITCH_FILTER_EN`:
  - Defined: after the synchronizers, SCL and SDA each pass a 3-sample majority filter. Pulses of 1 clk are suppressed, and input-to-event latency becomes 5 clk.
  - Undefined: no filter; latency 3 clk.
  - Protocol behaviour is otherwise identical.

## Test plan
- Write to 0x10, reg 0x03, data 0xA5, 0x5A -> ACK on all bytes; `reg_we` pulses at addr 3 (0xA5) and addr 4 (0x5A); `stop_det` pulses once.
- Write reg 0x02, repeated START, read 3 bytes with `reg_rdata`=addr^0xF0 -> SDA returns 0xF2, 0xF3, 0xF4; master NACK after the 3rd byte -> IDLE, no 4th `reg_re`.
- Call to address 0x11 -> NACK, `busy` stays 0, no strobes; a following valid transaction succeeds.
- WRAP=1, DEPTH=16, write 3 bytes starting at reg 0x0F -> `reg_we` at 15, 0, 1. WRAP=0, same stimulus -> write at 15 only, NACK on the 2nd and 3rd data bytes.
- Assert `rst` while SDA is driven low during an ACK -> `sda_oe`=0 on the next clk, state IDLE, pointer 0.
- With the filter macro defined, inject a 1-clk SDA low glitch while SCL is high -> no `start_det`. Without the macro -> `start_det` pulses.
